// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes and default widths for the 24-bit ALU
package alu_pkg;
    localparam int DEFAULT_WIDTH     = 24;
    localparam int DEFAULT_IMM_WIDTH = 8;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_MULI = 4'b1101;
endpackage

// File: rtl/alu24_comb.sv
// alu24_comb: combinational opcode decode and datapath producing the next result
module alu24_comb
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int IMM_WIDTH = DEFAULT_IMM_WIDTH
) (
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [IMM_WIDTH-1:0] absVal,
    input  logic [3:0]           alu_control,
    output logic [WIDTH-1:0]     next_result
);
    logic [WIDTH-1:0] imm;
    assign imm = {{(WIDTH-IMM_WIDTH){1'b0}}, absVal};
    // select the operation; unused codes yield zero and the default keeps it latch-free
    always_comb begin
        case (alu_control)
            OP_ADD:  next_result = in1 + in2;
            OP_SUB:  next_result = in1 - in2;
            OP_MUL:  next_result = in1 * in2;
            OP_XOR:  next_result = in1 ^ in2;
            OP_NOT:  next_result = ~in1;
            OP_AND:  next_result = in1 & in2;
            OP_OR:   next_result = in1 | in2;
            OP_ADDI: next_result = in1 + imm;
            OP_MULI: next_result = in1 * imm;
            default: next_result = '0;
        endcase
    end
endmodule

// File: rtl/alu24.sv
// alu24: execute-stage ALU with registered result and zero flag
module alu24
    import alu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int IMM_WIDTH = DEFAULT_IMM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [IMM_WIDTH-1:0] absVal,
    input  logic [3:0]           alu_control,
    output logic [WIDTH-1:0]     alu_result,
    output logic                 zero
);
    logic [WIDTH-1:0] next_result;
    alu24_comb #(.WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH)) u_comb (
        .in1         (in1),
        .in2         (in2),
        .absVal      (absVal),
        .alu_control (alu_control),
        .next_result (next_result)
    );
    // register result and its zero flag together so they never disagree
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_result <= '0;
            zero       <= 1'b1;
        end else begin
            alu_result <= next_result;
            zero       <= (next_result == '0);
        end
    end
endmodule

// File: tb/tb_alu24.sv
// tb_alu24: vector table, directed sequences and random checks against a reference model
module tb_alu24;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] in1 = '0;
    logic [23:0] in2 = '0;
    logic [7:0]  absVal = '0;
    logic [3:0]  alu_control = '0;
    logic [23:0] alu_result;
    logic        zero;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [23:0] a;
        logic [23:0] b;
        logic [7:0]  imm;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu24 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in1         (in1),
        .in2         (in2),
        .absVal      (absVal),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model(input logic [3:0] op, input logic [23:0] a,
                                          input logic [23:0] b, input logic [7:0] imm);
        longint unsigned x = a, y = b, k = imm, m = 64'd1 << 24, r;
        case (op)
            4'd0:  r = x + y;
            4'd1:  r = x + m - y;
            4'd2:  r = x * y;
            4'd3:  r = x ^ y;
            4'd4:  r = (m - 1) - x;
            4'd5:  r = x & y;
            4'd6:  r = x | y;
            4'd12: r = x + k;
            4'd13: r = x * k;
            default: r = 0;
        endcase
        return 24'(r % m);
    endfunction

    task automatic drive(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [7:0] imm);
        alu_control = op;
        in1 = a;
        in2 = b;
        absVal = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] exp);
        n_checks++;
        if (alu_result !== exp || zero !== (exp == 24'd0)) begin
            n_fail++;
            $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                     name, alu_result, zero, exp, exp == 24'd0);
        end
    endtask

    initial begin
        vecs.push_back('{"add", 4'h0, 24'd8, 24'd4, 8'h55, 24'd12});
        vecs.push_back('{"sub", 4'h1, 24'd16, 24'd2, 8'h00, 24'd14});
        vecs.push_back('{"mul", 4'h2, 24'd5, 24'd3, 8'h00, 24'd15});
        vecs.push_back('{"sub_wrap", 4'h1, 24'd2, 24'd16, 8'h00, 24'hFFFFF2});
        vecs.push_back('{"mul_trunc", 4'h2, 24'h001000, 24'h001000, 8'h00, 24'h000000});
        vecs.push_back('{"addi", 4'hC, 24'd9, 24'h123456, 8'd4, 24'd13});
        vecs.push_back('{"muli", 4'hD, 24'd5, 24'hFFFFFF, 8'd3, 24'd15});
        vecs.push_back('{"addi_wrap", 4'hC, 24'hFFFFFF, 24'h000777, 8'd1, 24'd0});
        vecs.push_back('{"addi_in2", 4'hC, 24'd9, 24'hABCDEF, 8'd4, 24'd13});
        vecs.push_back('{"xor", 4'h3, 24'hFF, 24'h01, 8'h00, 24'hFE});
        vecs.push_back('{"not", 4'h4, 24'h0, 24'h123456, 8'hFF, 24'hFFFFFF});
        vecs.push_back('{"and", 4'h5, 24'h0F, 24'h04, 8'h00, 24'h04});
        vecs.push_back('{"or", 4'h6, 24'h04, 24'h0F, 8'h00, 24'h0F});
        vecs.push_back('{"undef7", 4'h7, 24'hABCDEF, 24'hABCDEF, 8'h12, 24'd0});
        vecs.push_back('{"undefA", 4'hA, 24'hABCDEF, 24'hABCDEF, 8'h12, 24'd0});
        vecs.push_back('{"undefF", 4'hF, 24'hABCDEF, 24'hABCDEF, 8'h12, 24'd0});

        rst_n = 1'b0;
        drive(4'h0, 24'd8, 24'd4, 8'd0);
        check("reset_cycle1", 24'd0);
        drive(4'h0, 24'd8, 24'd4, 8'd0);
        check("reset_cycle2", 24'd0);
        rst_n = 1'b1;
        drive(4'h0, 24'd8, 24'd4, 8'd0);
        check("reset_release", 24'd12);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
            check(vecs[i].name, vecs[i].exp);
        end

        drive(4'h0, 24'd100, 24'd23, 8'd0);
        check("stream_add", 24'd123);
        drive(4'h1, 24'd50, 24'd7, 8'd0);
        check("stream_sub", 24'd43);
        rst_n = 1'b0;
        drive(4'h2, 24'd6, 24'd7, 8'd0);
        check("stream_reset", 24'd0);
        rst_n = 1'b1;
        drive(4'h2, 24'd6, 24'd7, 8'd0);
        check("stream_mul", 24'd42);
        drive(4'h3, 24'hF0F0F0, 24'h0FF00F, 8'd0);
        check("stream_xor", 24'hFF00FF);

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  op;
            logic [23:0] a, b;
            logic [7:0]  k;
            op = 4'($urandom_range(0, 15));
            a = 24'($urandom);
            b = (i % 8 == 0) ? a : 24'($urandom);
            k = 8'($urandom);
            drive(op, a, b, k);
            check("random", model(op, a, b, k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
